// File: rtl/data_mem_responder.sv
// Word-organised data memory for single-outstanding load/store requests; response pulses WAIT_CYCLES+1 edges after accept.
// req_ready is high only while idle, so one request is in flight at a time; bad alignment or range gives resp_err.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LIM_W = ADDR_W + 1;
  localparam logic [LIM_W-1:0] LIMIT = LIM_W'(DEPTH * 4);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [DEPTH];

  logic [IDX_W-1:0]  widx;
  logic [4:0]        lane_sh;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [31:0]       merged;
  logic              acc_err;
  logic              mem_we;
  logic [31:0]       mem_wdat;

  assign widx    = addr_q[IDX_W+1:2];
  assign lane_sh = {addr_q[1:0], 3'b000};
  assign rd_word = mem_q[widx];
  assign rd_byte = 8'(rd_word >> lane_sh);
  assign acc_err = (!byte_q && (addr_q[1:0] != 2'b00)) || ({1'b0, addr_q} >= LIMIT);

  // Byte store rewrites one lane of the current word, keeping the other three.
  always_comb begin
    merged = rd_word;
    merged[lane_sh +: 8] = wdata_q[7:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    byte_d   = byte_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    mem_wdat = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          byte_d  = req_byte;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          err_d   = acc_err;
          if (acc_err || we_q) begin
            rdata_d = 32'd0;
          end else begin
            rdata_d = byte_q ? {24'd0, rd_byte} : rd_word;
          end
          if (!acc_err && we_q) begin
            mem_we   = 1'b1;
            mem_wdat = byte_q ? merged : wdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (mem_we) mem_q[widx] <= mem_wdat;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three builds (default, DEPTH=32, WAIT_CYCLES=0) share clock, reset and request bus.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld   [3];
  logic        rdy   [3];
  logic        rvld  [3];
  logic        rerr  [3];
  logic [31:0] rdata [3];
  logic        we, bt;
  logic [7:0]  addr;
  logic [31:0] wdata;

  int n_pass = 0;
  int n_tot  = 0;

  logic [31:0] rd, rda, d_a, d_b;
  logic        er, rva, seen;
  int          lat;
  logic [9:0]  rdy_m, rv_m;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(2)) u_d0 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we), .req_byte(bt),
    .req_addr(addr), .req_wdata(wdata), .resp_valid(rvld[0]), .resp_rdata(rdata[0]), .resp_err(rerr[0]));

  data_mem_responder #(.ADDR_W(8), .DEPTH(32), .WAIT_CYCLES(2)) u_d1 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we), .req_byte(bt),
    .req_addr(addr), .req_wdata(wdata), .resp_valid(rvld[1]), .resp_rdata(rdata[1]), .resp_err(rerr[1]));

  data_mem_responder #(.ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(0)) u_d2 (
    .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(we), .req_byte(bt),
    .req_addr(addr), .req_wdata(wdata), .resp_valid(rvld[2]), .resp_rdata(rdata[2]), .resp_err(rerr[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // One request on instance d; lat counts edges from acceptance to the response cycle.
  task automatic txn(input int d, input logic w, input logic b, input logic [7:0] a,
                     input logic [31:0] wd, output logic [31:0] o_rd, output logic o_er,
                     output int o_lat, output logic o_rv_after, output logic [31:0] o_rd_after);
    int n;
    n = 0;
    we = w; bt = b; addr = a; wdata = wd;
    vld[d] = 1'b1;
    while (!rdy[d] && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    vld[d] = 1'b0;
    o_lat = 0;
    while (!rvld[d] && o_lat < 50) begin @(posedge clk); #1; o_lat++; end
    o_rd = rdata[d];
    o_er = rerr[d];
    @(posedge clk); #1;
    o_rv_after = rvld[d];
    o_rd_after = rdata[d];
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    we = 1'b0; bt = 1'b0; addr = 8'h00; wdata = 32'd0;
    #2;
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_resp_valid", 32'(rvld[0]), 32'd0);
    chk("rst_rdata", rdata[0], 32'd0);
    chk("rst_err", 32'(rerr[0]), 32'd0);
    #20 rst = 1'b0;
    @(posedge clk); #1;

    // Word store then load
    txn(0, 1'b1, 1'b0, 8'h10, 32'hDEADBEEF, rd, er, lat, rva, rda);
    chk("st_lat", 32'(lat), 32'd3);
    chk("st_err", 32'(er), 32'd0);
    chk("st_rdata", rd, 32'd0);
    chk("st_pulse_width", 32'(rva), 32'd0);
    txn(0, 1'b0, 1'b0, 8'h10, 32'd0, rd, er, lat, rva, rda);
    chk("ld_lat", 32'(lat), 32'd3);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    chk("ld_err", 32'(er), 32'd0);

    // Byte lanes
    txn(0, 1'b1, 1'b0, 8'h20, 32'h11223344, rd, er, lat, rva, rda);
    txn(0, 1'b1, 1'b1, 8'h22, 32'h555555AA, rd, er, lat, rva, rda);
    chk("bst_err", 32'(er), 32'd0);
    chk("bst_rdata", rd, 32'd0);
    txn(0, 1'b0, 1'b0, 8'h20, 32'd0, rd, er, lat, rva, rda);
    chk("lane_word", rd, 32'h11AA3344);
    txn(0, 1'b0, 1'b1, 8'h23, 32'd0, rd, er, lat, rva, rda);
    chk("lane_byte3", rd, 32'h00000011);
    chk("rdata_held", rda, 32'h00000011);

    // Errors
    txn(0, 1'b0, 1'b0, 8'h06, 32'd0, rd, er, lat, rva, rda);
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_rdata", rd, 32'd0);
    txn(1, 1'b1, 1'b0, 8'h04, 32'hCAFEF00D, rd, er, lat, rva, rda);
    chk("d32_st_err", 32'(er), 32'd0);
    txn(1, 1'b1, 1'b0, 8'hFC, 32'hFFFFFFFF, rd, er, lat, rva, rda);
    chk("range_st_err", 32'(er), 32'd1);
    txn(1, 1'b1, 1'b0, 8'h06, 32'hFFFFFFFF, rd, er, lat, rva, rda);
    chk("misalign_st_err", 32'(er), 32'd1);
    txn(1, 1'b0, 1'b1, 8'h80, 32'd0, rd, er, lat, rva, rda);
    chk("range_bld_err", 32'(er), 32'd1);
    chk("range_bld_rdata", rd, 32'd0);
    txn(1, 1'b0, 1'b0, 8'h04, 32'd0, rd, er, lat, rva, rda);
    chk("word4_intact", rd, 32'hCAFEF00D);
    chk("word4_err", 32'(er), 32'd0);
    txn(1, 1'b0, 1'b0, 8'h7C, 32'd0, rd, er, lat, rva, rda);
    chk("word31_intact", rd, 32'd0);

    // Zero wait states
    txn(2, 1'b1, 1'b0, 8'h30, 32'h0BADCAFE, rd, er, lat, rva, rda);
    chk("w0_st_lat", 32'(lat), 32'd1);
    txn(2, 1'b0, 1'b0, 8'h30, 32'd0, rd, er, lat, rva, rda);
    chk("w0_ld_lat", 32'(lat), 32'd1);
    chk("w0_ld_rdata", rd, 32'h0BADCAFE);
    txn(2, 1'b0, 1'b1, 8'h31, 32'd0, rd, er, lat, rva, rda);
    chk("w0_bld_rdata", rd, 32'h000000CA);

    // Handshake: valid held high across two requests; the inputs change right after the first accept
    we = 1'b0; bt = 1'b0; addr = 8'h10; vld[0] = 1'b1;
    rdy_m = '0; rv_m = '0; d_a = '0; d_b = '0;
    @(posedge clk); #1;
    addr = 8'h20;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      rdy_m[i] = rdy[0];
      rv_m[i]  = rvld[0];
      if (i == 3) d_a = rdata[0];
      if (i == 8) d_b = rdata[0];
      if (i == 5) vld[0] = 1'b0;
    end
    chk("hs_ready_mask", 32'(rdy_m), 32'h210);
    chk("hs_valid_mask", 32'(rv_m), 32'h108);
    chk("hs_first_data", d_a, 32'hDEADBEEF);
    chk("hs_second_data", d_b, 32'h11AA3344);

    // Reset during the wait phase of a store
    we = 1'b1; bt = 1'b0; addr = 8'h08; wdata = 32'h12345678; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(rdy[0]), 32'd1);
    chk("mid_rst_valid", 32'(rvld[0]), 32'd0);
    chk("mid_rst_rdata", rdata[0], 32'd0);
    #10 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | rvld[0];
    end
    chk("mid_rst_no_resp", 32'(seen), 32'd0);
    txn(0, 1'b0, 1'b0, 8'h08, 32'd0, rd, er, lat, rva, rda);
    chk("mid_rst_no_write", rd, 32'd0);
    txn(0, 1'b0, 1'b0, 8'h10, 32'd0, rd, er, lat, rva, rda);
    chk("mid_rst_mem_clear", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
